// File: rtl/bc_core_pkg.sv
// Shared BureCore fetch definitions: instruction size, default reset vector
// and the buffered {pc, instr} entry type.
package BC_core_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PKG_DATA_WIDTH = 32;
  localparam int unsigned PKG_INSTR_WIDTH = 32;
  localparam logic [PKG_DATA_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PKG_DATA_WIDTH-1:0]  pc;
    logic [PKG_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word-aligned.
  function automatic logic [PKG_DATA_WIDTH-1:0] word_align(input logic [PKG_DATA_WIDTH-1:0] addr);
    return addr & ~PKG_DATA_WIDTH'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/bc_fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop,
// and a push into a full FIFO is only taken when a pop frees the slot.
module bc_fetch_fifo
  import BC_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type T = fetch_entry_t,
  parameter int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output T              head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bc_stage_if.sv
// BureCore instruction fetch stage: owns the PC, issues credit-limited word
// fetches, buffers in-order responses and squashes stale ones on redirect.
module bc_stage_if
  import BC_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_redirect_valid,
  input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req_valid,
  input  logic                   i_imem_req_ready,
  output logic [DATA_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_resp_data,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0]  o_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic [DATA_WIDTH-1:0] redirect_pc_s;
  logic [CW:0]           inflight_s;
  logic                  req_fire_s;
  logic                  resp_keep_s;
  logic                  pop_s;
  entry_t                push_entry_s;
  entry_t                head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CW-1:0]         fifo_count_s;

  assign redirect_pc_s = i_redirect_pc & ALIGN_MASK;

  // Outstanding requests (including ones already marked for drop) plus
  // buffered entries may never exceed the FIFO capacity.
  assign inflight_s       = {1'b0, outst_q} + {1'b0, fifo_count_s};
  assign o_imem_req_valid = i_rstn && !i_redirect_valid && !fifo_full_s && (inflight_s < CREDITS);
  assign o_imem_addr      = fetch_pc_q;
  assign req_fire_s       = o_imem_req_valid && i_imem_req_ready;

  assign resp_keep_s  = i_imem_resp_valid && (drop_q == '0) && !i_redirect_valid;
  assign push_entry_s = {resp_pc_q, i_imem_resp_data};
  assign pop_s        = o_instr_valid && i_instr_ready;

  bc_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t),
    .CW    (CW)
  ) u_fifo (
    .clk_i       (i_clk),
    .rstn_i      (i_rstn),
    .push_i      (resp_keep_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .flush_i     (i_redirect_valid),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  assign o_instr_valid = !fifo_empty_s;
  assign o_instr       = head_s.instr;
  assign o_pc          = head_s.pc;

  // Next-state for PCs and counters; a redirect-cycle response is counted
  // out of outstanding before the remainder becomes the drop count.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    case ({req_fire_s, i_imem_resp_valid})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (i_redirect_valid) begin
      fetch_pc_d = redirect_pc_s;
      resp_pc_d  = redirect_pc_s;
      drop_d     = outst_d;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (i_imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + PC_STEP;
        end
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule
